// File: rtl/ram_dual_read_arbiter_pkg.sv
// Shared sizing constants and small index helpers for the dual-read RAM arbiter.
// Every arbiter file imports this package.
package ram_dual_read_arbiter_pkg;

  localparam int DATA_ROW_WIDTH     = 16;
  localparam int DATA_ADDRESS_WIDTH = 7;
  localparam int RAM_ARB_NUM_REQ    = 4;

  typedef enum logic [0:0] {
    PICK_ONE = 1'b0,
    PICK_TWO = 1'b1
  } pick_mode_e;

  // Both operands are below n, so a single conditional subtract is enough.
  function automatic int mod_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return mod_add(idx, 1, n);
  endfunction

endpackage

// File: rtl/ram_dual_read_arbiter_if.sv
// Requester bus and RAM pin bundle of the dual-read RAM arbiter.
// The arbiter uses the slave view; requesters and the RAM use the master view.
interface ram_dual_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);

  logic [NUM_REQ-1:0]            iReqValid;
  logic [NUM_REQ-1:0]            iReqWrite;
  logic [NUM_REQ*ADDR_WIDTH-1:0] iReqAddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData;
  logic [NUM_REQ-1:0]            oReqGrant;
  logic [NUM_REQ-1:0]            oRspValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] oRspData;

  logic                          oRamWriteEnable;
  logic [ADDR_WIDTH-1:0]         oRamWriteAddress;
  logic [DATA_WIDTH-1:0]         oRamDataIn;
  logic [ADDR_WIDTH-1:0]         oRamReadAddress0;
  logic [ADDR_WIDTH-1:0]         oRamReadAddress1;
  logic [DATA_WIDTH-1:0]         iRamDataOut0;
  logic [DATA_WIDTH-1:0]         iRamDataOut1;

  modport slave (
    input  iReqValid,
    input  iReqWrite,
    input  iReqAddr,
    input  iReqData,
    output oReqGrant,
    output oRspValid,
    output oRspData,
    output oRamWriteEnable,
    output oRamWriteAddress,
    output oRamDataIn,
    output oRamReadAddress0,
    output oRamReadAddress1,
    input  iRamDataOut0,
    input  iRamDataOut1
  );

  modport master (
    output iReqValid,
    output iReqWrite,
    output iReqAddr,
    output iReqData,
    input  oReqGrant,
    input  oRspValid,
    input  oRspData,
    input  oRamWriteEnable,
    input  oRamWriteAddress,
    input  oRamDataIn,
    input  oRamReadAddress0,
    input  oRamReadAddress1,
    output iRamDataOut0,
    output iRamDataOut1
  );

endinterface

// File: rtl/ram_dual_read_arbiter_rr_pick_two.sv
// Round-robin picker: rotate the request vector to start at ptr_i, find the first
// and (in PICK_TWO mode) second set bit, then map both back to requester indices.
module ram_dual_read_arbiter_rr_pick_two
  import ram_dual_read_arbiter_pkg::*;
#(
  parameter int         N    = 4,
  parameter int         PW   = (N > 1) ? $clog2(N) : 1,
  parameter pick_mode_e MODE = PICK_TWO
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          first_vld_o,
  output logic [PW-1:0] first_idx_o,
  output logic          second_vld_o,
  output logic [PW-1:0] second_idx_o
);

  logic [N-1:0]  rot_s;
  logic [N-1:0]  rot_rest_s;
  logic [N-1:0]  first_onehot_s;
  logic [PW-1:0] first_k_s;
  logic [PW-1:0] second_k_s;

  // Rotate so that bit 0 is the requester the pointer currently favours.
  always_comb begin
    rot_s = '0;
    for (int k = 0; k < N; k++) begin
      rot_s[k] = req_i[PW'(mod_add(int'(ptr_i), k, N))];
    end
  end

  // Descending scans leave the lowest set position; the second scan skips the first winner.
  always_comb begin
    first_k_s      = '0;
    second_k_s     = '0;
    first_onehot_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      first_k_s = rot_s[k] ? PW'(k) : first_k_s;
    end
    for (int k = 0; k < N; k++) begin
      first_onehot_s[k] = (first_k_s == PW'(k));
    end
    rot_rest_s = rot_s & ~first_onehot_s;
    for (int k = N - 1; k >= 0; k--) begin
      second_k_s = rot_rest_s[k] ? PW'(k) : second_k_s;
    end
  end

  // Undo the rotation to obtain real requester indices.
  always_comb begin
    first_vld_o  = |rot_s;
    second_vld_o = (MODE == PICK_TWO) && (|rot_rest_s);
    first_idx_o  = PW'(mod_add(int'(first_k_s), int'(ptr_i), N));
    second_idx_o = PW'(mod_add(int'(second_k_s), int'(ptr_i), N));
  end

endmodule

// File: rtl/ram_dual_read_arbiter.sv
// Shares a dual-read / single-write RAM among NUM_REQ requesters: one round-robin
// write grant and up to two round-robin read grants per cycle, read data returned one cycle later.
module ram_dual_read_arbiter
  import ram_dual_read_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_ROW_WIDTH,
  parameter int ADDR_WIDTH = DATA_ADDRESS_WIDTH,
  parameter int NUM_REQ    = RAM_ARB_NUM_REQ
) (
  input  logic                    Clock,
  input  logic                    Reset,
  ram_dual_read_arbiter_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  busy0_q, busy0_d;
  logic                  busy1_q, busy1_d;
  logic [PW-1:0]         owner0_q, owner0_d;
  logic [PW-1:0]         owner1_q, owner1_d;

  logic [NUM_REQ-1:0]    wr_req_s;
  logic [NUM_REQ-1:0]    rd_elig_s;
  logic                  wr_vld_s;
  logic [PW-1:0]         wr_idx_s;
  logic                  wr_second_vld_s;
  logic [PW-1:0]         wr_second_idx_s;
  logic                  unused_wr_second_s;
  logic                  rd0_vld_s;
  logic [PW-1:0]         rd0_idx_s;
  logic                  rd1_vld_s;
  logic [PW-1:0]         rd1_idx_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [ADDR_WIDTH-1:0] rd0_addr_s;
  logic [ADDR_WIDTH-1:0] rd1_addr_s;

  assign wr_req_s           = bus.iReqValid & bus.iReqWrite;
  assign unused_wr_second_s = ^{wr_second_vld_s, wr_second_idx_s};

  ram_dual_read_arbiter_rr_pick_two #(
    .N    (NUM_REQ),
    .PW   (PW),
    .MODE (PICK_ONE)
  ) u_wr_pick (
    .req_i        (wr_req_s),
    .ptr_i        (wr_ptr_q),
    .first_vld_o  (wr_vld_s),
    .first_idx_o  (wr_idx_s),
    .second_vld_o (wr_second_vld_s),
    .second_idx_o (wr_second_idx_s)
  );

  // Select the winning writer's address and data.
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_addr_s = (wr_idx_s == PW'(i)) ? bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] : wr_addr_s;
      wr_data_s = (wr_idx_s == PW'(i)) ? bus.iReqData[i*DATA_WIDTH +: DATA_WIDTH] : wr_data_s;
    end
  end

  // A read hitting this cycle's write address waits one cycle so it sees the new data.
  always_comb begin
    rd_elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_elig_s[i] = bus.iReqValid[i] && !bus.iReqWrite[i] &&
                     !(wr_vld_s && (bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_s));
    end
  end

  ram_dual_read_arbiter_rr_pick_two #(
    .N    (NUM_REQ),
    .PW   (PW),
    .MODE (PICK_TWO)
  ) u_rd_pick (
    .req_i        (rd_elig_s),
    .ptr_i        (rd_ptr_q),
    .first_vld_o  (rd0_vld_s),
    .first_idx_o  (rd0_idx_s),
    .second_vld_o (rd1_vld_s),
    .second_idx_o (rd1_idx_s)
  );

  // Select the read addresses for both RAM ports.
  always_comb begin
    rd0_addr_s = '0;
    rd1_addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd0_addr_s = (rd0_idx_s == PW'(i)) ? bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] : rd0_addr_s;
      rd1_addr_s = (rd1_idx_s == PW'(i)) ? bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] : rd1_addr_s;
    end
  end

  // Grants and RAM pins, all held at zero while reset is asserted.
  always_comb begin
    bus.oReqGrant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.oReqGrant[i] = Reset &&
                         ((wr_vld_s  && (wr_idx_s  == PW'(i))) ||
                          (rd0_vld_s && (rd0_idx_s == PW'(i))) ||
                          (rd1_vld_s && (rd1_idx_s == PW'(i))));
    end
    bus.oRamWriteEnable  = Reset && wr_vld_s;
    bus.oRamWriteAddress = (Reset && wr_vld_s)  ? wr_addr_s  : '0;
    bus.oRamDataIn       = (Reset && wr_vld_s)  ? wr_data_s  : '0;
    bus.oRamReadAddress0 = (Reset && rd0_vld_s) ? rd0_addr_s : '0;
    bus.oRamReadAddress1 = (Reset && rd1_vld_s) ? rd1_addr_s : '0;
  end

  // Next pointer sits just past the last winner of each class; owners follow the read ports.
  always_comb begin
    wr_ptr_d = wr_vld_s ? PW'(wrap_inc(int'(wr_idx_s), NUM_REQ)) : wr_ptr_q;
    if (rd1_vld_s) begin
      rd_ptr_d = PW'(wrap_inc(int'(rd1_idx_s), NUM_REQ));
    end else if (rd0_vld_s) begin
      rd_ptr_d = PW'(wrap_inc(int'(rd0_idx_s), NUM_REQ));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    busy0_d  = rd0_vld_s;
    busy1_d  = rd1_vld_s;
    owner0_d = rd0_vld_s ? rd0_idx_s : '0;
    owner1_d = rd1_vld_s ? rd1_idx_s : '0;
  end

  // Pointer and response-tracking registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy0_q  <= 1'b0;
      busy1_q  <= 1'b0;
      owner0_q <= '0;
      owner1_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy0_q  <= busy0_d;
      busy1_q  <= busy1_d;
      owner0_q <= owner0_d;
      owner1_q <= owner1_d;
    end
  end

  // Steer registered RAM data to the requester that owned each port last cycle.
  always_comb begin
    bus.oRspValid = '0;
    bus.oRspData  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy0_q && (owner0_q == PW'(i))) begin
        bus.oRspValid[i]                        = 1'b1;
        bus.oRspData[i*DATA_WIDTH +: DATA_WIDTH] = bus.iRamDataOut0;
      end else if (busy1_q && (owner1_q == PW'(i))) begin
        bus.oRspValid[i]                        = 1'b1;
        bus.oRspData[i*DATA_WIDTH +: DATA_WIDTH] = bus.iRamDataOut1;
      end else begin
        bus.oRspValid[i]                        = 1'b0;
        bus.oRspData[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_dual_read_arbiter.sv
// Directed bench for ram_dual_read_arbiter with a behavioural 128-row RAM
// (registered read ports) attached to the arbiter's RAM pins.
module tb_ram_dual_read_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 7;

  logic Clock;
  logic Reset;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  logic [DW-1:0] mem [128];

  ram_dual_read_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_dual_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model: synchronous write, registered reads; contents preset while in reset.
  always @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'h1000 + 16'(i);
      bus.iRamDataOut0 <= 16'h0000;
      bus.iRamDataOut1 <= 16'h0000;
    end else begin
      if (bus.oRamWriteEnable) mem[bus.oRamWriteAddress] <= bus.oRamDataIn;
      bus.iRamDataOut0 <= mem[bus.oRamReadAddress0];
      bus.iRamDataOut1 <= mem[bus.oRamReadAddress1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.iReqValid[i]          = v;
    bus.iReqWrite[i]          = w;
    bus.iReqAddr[i*AW +: AW]  = a;
    bus.iReqData[i*DW +: DW]  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 7'd0, 16'h0000);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rsp(input int i);
    return bus.oRspData[i*DW +: DW];
  endfunction

  logic [NR-1:0] exp_wgrant [5];

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    Reset     = 1'b0;
    clear_all();
    set_req(0, 1'b1, 1'b1, 7'd9, 16'h00FF);

    // In reset: everything combinational is forced low despite a pending write.
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_grant", bus.oReqGrant, 4'b0000);
    chk("rst_we", bus.oRamWriteEnable, 1'b0);
    chk("rst_waddr", bus.oRamWriteAddress, 7'd0);
    chk("rst_din", bus.oRamDataIn, 16'h0000);
    chk("rst_rspv", bus.oRspValid, 4'b0000);
    chk("rst_rspd", bus.oRspData, 64'h0);
    clear_all();
    step();
    Reset = 1'b1;

    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      chk("idle_grant", bus.oReqGrant, 4'b0000);
      chk("idle_we", bus.oRamWriteEnable, 1'b0);
      chk("idle_rspv", bus.oRspValid, 4'b0000);
    end

    // T0: req0 writes 0xA5 to address 5.
    step();
    set_req(0, 1'b1, 1'b1, 7'd5, 16'h00A5);
    @(negedge Clock);
    chk("t0_grant", bus.oReqGrant, 4'b0001);
    chk("t0_we", bus.oRamWriteEnable, 1'b1);
    chk("t0_waddr", bus.oRamWriteAddress, 7'd5);
    chk("t0_din", bus.oRamDataIn, 16'h00A5);

    // T1: req1 reads address 5.
    step();
    set_req(0, 1'b0, 1'b0, 7'd0, 16'h0000);
    set_req(1, 1'b1, 1'b0, 7'd5, 16'h0000);
    @(negedge Clock);
    chk("t1_grant", bus.oReqGrant, 4'b0010);
    chk("t1_raddr0", bus.oRamReadAddress0, 7'd5);
    chk("t1_we", bus.oRamWriteEnable, 1'b0);
    chk("t1_rspv", bus.oRspValid, 4'b0000);

    // T2: req2 writes 7 while req3 reads 7 -> read deferred; req1's data returns.
    step();
    set_req(1, 1'b0, 1'b0, 7'd0, 16'h0000);
    set_req(2, 1'b1, 1'b1, 7'd7, 16'h0033);
    set_req(3, 1'b1, 1'b0, 7'd7, 16'h0000);
    @(negedge Clock);
    chk("t2_grant", bus.oReqGrant, 4'b0100);
    chk("t2_waddr", bus.oRamWriteAddress, 7'd7);
    chk("t2_rspv", bus.oRspValid, 4'b0010);
    chk("t2_rspd1", rsp(1), 16'h00A5);
    chk("t2_rspd0", rsp(0), 16'h0000);

    // T3: deferred read now granted.
    step();
    set_req(2, 1'b0, 1'b0, 7'd0, 16'h0000);
    @(negedge Clock);
    chk("t3_grant", bus.oReqGrant, 4'b1000);
    chk("t3_raddr0", bus.oRamReadAddress0, 7'd7);
    chk("t3_rspv", bus.oRspValid, 4'b0000);

    // T4..T6: all four read addresses 1..4 continuously.
    step();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 7'(i + 1), 16'h0000);
    @(negedge Clock);
    chk("t4_rspv", bus.oRspValid, 4'b1000);
    chk("t4_rspd3", rsp(3), 16'h0033);
    chk("t4_grant", bus.oReqGrant, 4'b0011);
    chk("t4_raddr0", bus.oRamReadAddress0, 7'd1);
    chk("t4_raddr1", bus.oRamReadAddress1, 7'd2);

    step();
    @(negedge Clock);
    chk("t5_grant", bus.oReqGrant, 4'b1100);
    chk("t5_raddr0", bus.oRamReadAddress0, 7'd3);
    chk("t5_raddr1", bus.oRamReadAddress1, 7'd4);
    chk("t5_rspv", bus.oRspValid, 4'b0011);
    chk("t5_rspd0", rsp(0), 16'h1001);
    chk("t5_rspd1", rsp(1), 16'h1002);

    step();
    @(negedge Clock);
    chk("t6_grant", bus.oReqGrant, 4'b0011);
    chk("t6_rspv", bus.oRspValid, 4'b1100);
    chk("t6_rspd2", rsp(2), 16'h1003);
    chk("t6_rspd3", rsp(3), 16'h1004);
    chk("t6_rspd0", rsp(0), 16'h0000);

    // T7: only req0 reads; then reset hits while its response is in flight.
    step();
    for (int i = 1; i < NR; i++) set_req(i, 1'b0, 1'b0, 7'd0, 16'h0000);
    @(negedge Clock);
    chk("t7_grant", bus.oReqGrant, 4'b0001);
    chk("t7_rspv", bus.oRspValid, 4'b0011);

    step();
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst2_rspv", bus.oRspValid, 4'b0000);
    chk("rst2_rspd", bus.oRspData, 64'h0);
    chk("rst2_grant", bus.oReqGrant, 4'b0000);
    clear_all();
    step();
    Reset = 1'b1;

    // All four write continuously: one grant per cycle in order 0,1,2,3,0.
    exp_wgrant[0] = 4'b0001;
    exp_wgrant[1] = 4'b0010;
    exp_wgrant[2] = 4'b0100;
    exp_wgrant[3] = 4'b1000;
    exp_wgrant[4] = 4'b0001;
    step();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 7'(10 + i), 16'h00B0 + 16'(i));
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      chk("wr_grant", bus.oReqGrant, exp_wgrant[c]);
      chk("wr_we", bus.oRamWriteEnable, 1'b1);
      chk("wr_waddr", bus.oRamWriteAddress, 7'(10 + (c % NR)));
      chk("wr_din", bus.oRamDataIn, 16'h00B0 + 16'(c % NR));
      step();
    end

    // Read pointer restarted at 0 after reset: req0 on port 0, req3 on port 1.
    clear_all();
    set_req(0, 1'b1, 1'b0, 7'd20, 16'h0000);
    set_req(3, 1'b1, 1'b0, 7'd23, 16'h0000);
    @(negedge Clock);
    chk("pr_grant", bus.oReqGrant, 4'b1001);
    chk("pr_raddr0", bus.oRamReadAddress0, 7'd20);
    chk("pr_raddr1", bus.oRamReadAddress1, 7'd23);
    step();
    clear_all();
    @(negedge Clock);
    chk("pr_rspv", bus.oRspValid, 4'b1001);
    chk("pr_rspd0", rsp(0), 16'h1014);
    chk("pr_rspd3", rsp(3), 16'h1017);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_dual_read_arbiter.md
Name: ram_dual_read_arbiter

Overview:
- Shares the 128-row dual-read / single-write data RAM among NUM_REQ requesters (e.g. execution units, fetch, host loader).
- Each cycle it grants up to two reads (RAM read ports 0 and 1) and one write, each class round-robin.
- It drives the RAM address, data and write-enable pins, and steers registered read data back to the owning requester one cycle later.
- Enforces same-cycle read-after-write ordering by deferring conflicting reads.

Parameters:
- DATA_WIDTH, `DATA_ROW_WIDTH, RAM row width.
- ADDR_WIDTH, `DATA_ADDRESS_WIDTH, RAM address width.
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- Clock  input  1  single clock, posedge.
- Reset  input  1  asynchronous, active-low reset.
- iReqValid  input  NUM_REQ  request pending, one bit per requester.
- iReqWrite  input  NUM_REQ  1 = write request, 0 = read request.
- iReqAddr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- iReqData  input  NUM_REQ*DATA_WIDTH  packed write data.
- oReqGrant  output  NUM_REQ  combinational grant; the request is consumed this cycle.
- oRspValid  output  NUM_REQ  registered; read data valid for requester i.
- oRspData  output  NUM_REQ*DATA_WIDTH  packed read data; slice i is meaningful only while oRspValid[i] = 1.
- oRamWriteEnable  output  1  to RAM iWriteEnable.
- oRamWriteAddress  output  ADDR_WIDTH  to RAM iWriteAddress.
- oRamDataIn  output  DATA_WIDTH  to RAM iDataIn.
- oRamReadAddress0  output  ADDR_WIDTH  to RAM iReadAddress0.
- oRamReadAddress1  output  ADDR_WIDTH  to RAM iReadAddress1.
- iRamDataOut0  input  DATA_WIDTH  from RAM oDataOut0.
- iRamDataOut1  input  DATA_WIDTH  from RAM oDataOut1.

Behaviour:
- Requester protocol: hold iReqValid, iReqWrite, iReqAddr and iReqData stable until oReqGrant[i] is seen high at a posedge. The next request may be presented the following cycle. Grant never depends on oRspValid.
- Write arbitration: among valid write requests, pick the first at or after WrPtr (modulo NUM_REQ). Drive oRamWriteEnable = 1 with that requester's address and data. With no writer: oRamWriteEnable = 0, address and data 0.
- Read arbitration: among valid read requests, drop any whose address equals the write address granted this cycle (hazard deferral; retried next cycle). Scanning from RdPtr, the first eligible requester gets port 0 and the second gets port 1. Unused read ports drive address 0.
- Pointer update (registered):
  - WrPtr <= winner+1 when a write is granted.
  - RdPtr <= (last granted read requester)+1 when at least one read is granted.
  - Both wrap modulo NUM_REQ. Pointers hold when nothing is granted.
- Response pipeline:
  - At grant, register Owner0/Owner1 (requester index) and Busy0/Busy1.
  - Next cycle, oRspValid[Owner0] = Busy0 with slice = iRamDataOut0, and likewise for port 1.
  - Read latency is exactly 1 cycle after grant.
  - A read deferred by a hazard and granted one cycle later returns the newly written data, because the RAM write has completed.
- Two reads to the same address on both ports in one cycle are legal; both requesters receive the same data.
- A requester can never hold both ports in one cycle: one request per requester.
- Non-owner oRspData slices drive 0.
- Reset (asynchronous, Reset = 0):
  - WrPtr = 0, RdPtr = 0, Busy0/1 = 0, Owner0/1 = 0.
  - oRspValid = 0 and oRspData = 0 immediately. In-flight reads are dropped.
  - Grants and RAM outputs are combinational from requests and pointers. While Reset = 0 they are forced to 0: oReqGrant = 0, oRamWriteEnable = 0, all RAM addresses and data = 0.
- Starvation-free: any request held valid is granted within NUM_REQ cycles. A deferred read waits at most one extra cycle per write to the same address.

Decomposition:
- Shared package/defines (aDefinitions.v): `DATA_ROW_WIDTH, `DATA_ADDRESS_WIDTH, plus a new `RAM_ARB_NUM_REQ default.
- One sub-module: rr_pick_two, a combinational rotate, priority-find-first/second, unrotate block. Instantiated with a one-winner mode for writes and two-winner mode for reads, each with its own pointer.

Test Plan:
- Reset release, no requests -> oReqGrant = 0, oRamWriteEnable = 0, oRspValid = 0 for 5 cycles.
- Req0 writes addr 5 data 0xA5 at T0; req1 reads addr 5 at T1 -> grant0 at T0, WE = 1; grant1 at T1; oRspValid[1] = 1 at T1+1 with data 0xA5.
- Same cycle: req2 writes addr 7 data 0x33, req3 reads addr 7 -> only req2 granted; req3 granted next cycle; response data 0x33.
- Reqs 0..3 all read distinct addresses 1..4 continuously from RdPtr = 0 -> grants {0,1}, {2,3}, {0,1} on successive cycles; each response arrives 1 cycle after its grant on the correct slice.
- Reqs 0..3 all write continuously -> exactly one write grant per cycle, in order 0,1,2,3,0.
- Reset asserted the cycle after a read grant -> oRspValid stays 0; after release the pointers are 0 and the first grant goes to req0.
